// File: rtl/rv16_decode_stage.sv
// rv16 instruction decode stage: valid/ready in, one registered decoded-field stage out.
// Optional load-use interlock and bubble counter, enabled by defining RV16_DEC_LOADUSE_EN.
module rv16_decode_stage #(
    parameter int DATA   = 16,
    parameter int OPCODE = 4
) (
    input  logic              rv16_dec_clock,
    input  logic              rv16_dec_reset_n,
    input  logic              if_valid_in,
    input  logic [DATA-1:0]   if_instr_in,
    input  logic [DATA-1:0]   if_pc_in,
    output logic              dec_ready_out,
    input  logic              ex_ready_in,
    input  logic              flush_in,
    output logic              id_valid_out,
    output logic [DATA-1:0]   id_pc_out,
    output logic [OPCODE-1:0] id_rd_addr_out,
    output logic [OPCODE-1:0] id_rs1_addr_out,
    output logic [OPCODE-1:0] id_rs2_addr_out,
    output logic [DATA-1:0]   id_imm_out,
    output logic [2:0]        id_alu_op_out,
    output logic              id_reg_write_out,
    output logic              id_mem_read_out,
    output logic              id_mem_write_out,
    output logic              id_branch_out,
    output logic              id_jump_out,
    output logic              id_halt_out,
    output logic              id_illegal_out,
    output logic [15:0]       stall_count_out
);

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [OPCODE-1:0] rd;
        logic [OPCODE-1:0] rs1;
        logic [OPCODE-1:0] rs2;
        logic [DATA-1:0]   imm;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              halt;
        logic              illegal;
    } dec_t;

    state_t state_q, state_d;
    dec_t   dec;
    logic   adv;
    logic   accept;
    logic   lu_stall;

    logic [3:0] f_op, f_a, f_b, f_c;
    logic [DATA-1:0] sext4, sext8;

    assign f_op  = if_instr_in[15:12];
    assign f_a   = if_instr_in[11:8];
    assign f_b   = if_instr_in[7:4];
    assign f_c   = if_instr_in[3:0];
    assign sext4 = {{(DATA-4){f_c[3]}}, f_c};
    assign sext8 = {{(DATA-8){if_instr_in[7]}}, if_instr_in[7:0]};

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        dec = '0;
        case (f_op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dec.rd        = f_a;
                dec.rs1       = f_b;
                dec.rs2       = f_c;
                dec.alu_op    = f_op[2:0];
                dec.reg_write = 1'b1;
            end
            4'h8: begin
                dec.rd        = f_a;
                dec.rs1       = f_b;
                dec.imm       = sext4;
                dec.reg_write = 1'b1;
            end
            4'h9: begin
                dec.rd        = f_a;
                dec.imm       = sext8;
                dec.reg_write = 1'b1;
            end
            4'hA: begin
                dec.rd        = f_a;
                dec.rs1       = f_b;
                dec.imm       = sext4;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            4'hB: begin
                dec.rs2       = f_a;
                dec.rs1       = f_b;
                dec.imm       = sext4;
                dec.mem_write = 1'b1;
            end
            4'hC: begin
                dec.rs1       = f_a;
                dec.rs2       = f_b;
                dec.imm       = sext4;
                dec.alu_op    = 3'd1;
                dec.branch    = 1'b1;
            end
            4'hD: begin
                dec.rd        = f_a;
                dec.imm       = sext8;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            4'hE:    dec.illegal = 1'b1;
            default: dec.halt    = 1'b1;
        endcase
    end

    assign adv           = !id_valid_out || ex_ready_in;
    assign dec_ready_out = flush_in || (state_q == RUN && adv && !lu_stall);
    assign accept        = if_valid_in && dec_ready_out;

`ifdef RV16_DEC_LOADUSE_EN
    // Unused source fields decode to 0 and a hazard needs rd != 0, so a plain compare suffices.
    assign lu_stall = id_valid_out && id_mem_read_out && (id_rd_addr_out != '0) && if_valid_in
                      && ((dec.rs1 == id_rd_addr_out) || (dec.rs2 == id_rd_addr_out));

    always_ff @(posedge rv16_dec_clock or negedge rv16_dec_reset_n) begin
        if (!rv16_dec_reset_n) begin
            stall_count_out <= '0;
        end else if (!flush_in && adv && lu_stall && stall_count_out != 16'hFFFF) begin
            stall_count_out <= stall_count_out + 16'd1;
        end
    end
`else
    assign lu_stall        = 1'b0;
    assign stall_count_out = '0;
`endif

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = RUN;
        end else if (accept && dec.halt) begin
            state_d = HALTED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rv16_dec_clock or negedge rv16_dec_reset_n) begin
        if (!rv16_dec_reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge rv16_dec_clock or negedge rv16_dec_reset_n) begin
        if (!rv16_dec_reset_n) begin
            id_valid_out     <= 1'b0;
            id_pc_out        <= '0;
            id_rd_addr_out   <= '0;
            id_rs1_addr_out  <= '0;
            id_rs2_addr_out  <= '0;
            id_imm_out       <= '0;
            id_alu_op_out    <= '0;
            id_reg_write_out <= 1'b0;
            id_mem_read_out  <= 1'b0;
            id_mem_write_out <= 1'b0;
            id_branch_out    <= 1'b0;
            id_jump_out      <= 1'b0;
            id_halt_out      <= 1'b0;
            id_illegal_out   <= 1'b0;
        end else if (flush_in) begin
            id_valid_out <= 1'b0;
        end else if (adv) begin
            id_valid_out <= accept;
            if (accept) begin
                id_pc_out        <= if_pc_in;
                id_rd_addr_out   <= dec.rd;
                id_rs1_addr_out  <= dec.rs1;
                id_rs2_addr_out  <= dec.rs2;
                id_imm_out       <= dec.imm;
                id_alu_op_out    <= dec.alu_op;
                id_reg_write_out <= dec.reg_write;
                id_mem_read_out  <= dec.mem_read;
                id_mem_write_out <= dec.mem_write;
                id_branch_out    <= dec.branch;
                id_jump_out      <= dec.jump;
                id_halt_out      <= dec.halt;
                id_illegal_out   <= dec.illegal;
            end
        end
    end

endmodule
